// File: rtl/ahb_lite_uart_master_if.sv
// rtl/ahb_lite_uart_master_if.sv - AHB-Lite signal bundle between the UART master and its slave
//
// Purpose: groups the single-master AHB-Lite signals so the master and the slave
// (ahb_lite_sdram, or a testbench model) connect through one port.
// Signals:
//   HADDR[31:0]  master -> slave  transfer address
//   HBURST[2:0]  master -> slave  burst type (SINGLE only)
//   HSEL         master -> slave  slave select
//   HSIZE[2:0]   master -> slave  transfer size (32-bit only)
//   HTRANS[1:0]  master -> slave  IDLE / NONSEQ
//   HWDATA[31:0] master -> slave  write data
//   HWRITE       master -> slave  1 = write
//   HRDATA[31:0] slave -> master  read data
//   HREADY       slave -> master  transfer done / address accepted
//   HRESP        slave -> master  1 = ERROR
interface ahb_lite_uart_master_if;
  logic [31:0] HADDR;
  logic [2:0]  HBURST;
  logic        HSEL;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    output HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    input  HADDR, HBURST, HSEL, HSIZE, HTRANS, HWDATA, HWRITE,
    output HRDATA, HREADY, HRESP
  );
endinterface

// File: rtl/ahb_lite_uart_master.sv
// rtl/ahb_lite_uart_master.sv - UART-commanded single-transfer AHB-Lite master
//
// Purpose: receives 8N1 commands from a host and issues single 32-bit AHB-Lite
// transfers, replying with an acknowledge byte or the read data.
//   'W' A3..A0 D3..D0 -> write, reply 'K'     'R' A3..A0 -> read, reply 4 data bytes
//   other command byte -> reply '?'          HRESP=1 -> reply 'E'
// Optional macro AHB_UART_TIMEOUT_EN: abort a transfer after AHB_TIMEOUT cycles of
// HREADY=0 and reply 'T'. Without it the master waits for HREADY indefinitely.
// Ports:
//   HCLK     in   bus clock, rising edge
//   HRESETn  in   asynchronous active-low reset
//   UART_RX  in   serial command input (asynchronous, idle high)
//   UART_TX  out  serial reply output (idle high)
//   BUSY     out  high from accepted command byte until the last reply stop bit ends
//   ahb      master modport of ahb_lite_uart_master_if
module ahb_lite_uart_master #(
  parameter int BAUD_DIV = 434
`ifdef AHB_UART_TIMEOUT_EN
  , parameter int AHB_TIMEOUT = 1024
`endif
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic UART_RX,
  output logic UART_TX,
  output logic BUSY,
  ahb_lite_uart_master_if.master ahb
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(BAUD_DIV / 2 - 1);

  localparam logic [7:0] CMD_W   = 8'h57;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] RSP_K   = 8'h4B;
  localparam logic [7:0] RSP_UNK = 8'h3F;
  localparam logic [7:0] RSP_E   = 8'h45;

  typedef enum logic [2:0] {
    S_CMD, S_ADDR, S_DATA, S_AHB_A, S_AHB_D, S_REPLY
  } state_t;

  state_t state, state_next;

  // ---------------- UART receiver ----------------
  logic [1:0]    rx_sync;
  logic          rx_prev;
  logic          rx_active;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bitn;
  logic [7:0]    rx_shift;
  logic          rx_valid;
  logic          rx_ferr;
  logic          rx_s;

  assign rx_s = rx_sync[1];

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_sync   <= 2'b11;
      rx_prev   <= 1'b1;
      rx_active <= 1'b0;
      rx_cnt    <= '0;
      rx_bitn   <= '0;
      rx_shift  <= '0;
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_sync  <= {rx_sync[0], UART_RX};
      rx_prev  <= rx_s;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_active) begin
        if (rx_prev && !rx_s) begin
          rx_active <= 1'b1;
          rx_cnt    <= HALF_RELOAD;
          rx_bitn   <= 4'd0;
        end
      end else if (rx_cnt != '0) begin
        rx_cnt <= rx_cnt - 1'b1;
      end else begin
        rx_cnt <= BIT_RELOAD;
        if (rx_bitn == 4'd0) begin
          // A start bit that is high again at mid-bit was a glitch.
          if (rx_s) rx_active <= 1'b0;
          else      rx_bitn   <= 4'd1;
        end else if (rx_bitn != 4'd9) begin
          rx_shift <= {rx_s, rx_shift[7:1]};
          rx_bitn  <= rx_bitn + 4'd1;
        end else begin
          rx_active <= 1'b0;
          if (rx_s) rx_valid <= 1'b1;
          else      rx_ferr  <= 1'b1;
        end
      end
    end
  end

  // ---------------- UART transmitter ----------------
  logic          tx_busy;
  logic [9:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bitn;
  logic          tx_load;
  logic [7:0]    tx_data;
  logic          tx_end;
  logic          tx_ready;

  // Ready in the last cycle of a stop bit too, so the next byte follows with no gap.
  assign tx_end   = tx_busy && (tx_cnt == '0) && (tx_bitn == 4'd9);
  assign tx_ready = !tx_busy || tx_end;
  assign UART_TX  = tx_busy ? tx_shift[0] : 1'b1;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      tx_busy  <= 1'b0;
      tx_shift <= '1;
      tx_cnt   <= '0;
      tx_bitn  <= '0;
    end else if (tx_load) begin
      tx_busy  <= 1'b1;
      tx_shift <= {1'b1, tx_data, 1'b0};
      tx_cnt   <= BIT_RELOAD;
      tx_bitn  <= 4'd0;
    end else if (tx_busy) begin
      if (tx_cnt != '0) begin
        tx_cnt <= tx_cnt - 1'b1;
      end else if (tx_bitn == 4'd9) begin
        tx_busy <= 1'b0;
      end else begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_bitn  <= tx_bitn + 4'd1;
        tx_cnt   <= BIT_RELOAD;
      end
    end
  end

  // ---------------- command / bus datapath ----------------
  logic        is_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  byte_cnt;
  logic [31:0] reply_buf;   // next reply byte always in [31:24]
  logic [2:0]  reply_rem;
  logic        is_cmd;
  logic        timeout_hit;
  logic [1:0]  htrans;
  logic        hsel;
  logic        hwrite;

  assign is_cmd  = (rx_shift == CMD_W) || (rx_shift == CMD_R);
  assign tx_data = reply_buf[31:24];

`ifdef AHB_UART_TIMEOUT_EN
  localparam int TW = $clog2(AHB_TIMEOUT + 1);
  localparam logic [7:0] RSP_T = 8'h54;
  logic [TW-1:0] to_cnt;

  assign timeout_hit = ((state == S_AHB_A) || (state == S_AHB_D)) && !ahb.HREADY &&
                       (to_cnt == TW'(AHB_TIMEOUT - 1));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                                      to_cnt <= '0;
    else if ((state != S_AHB_A) && (state != S_AHB_D)) to_cnt <= '0;
    else if (!ahb.HREADY)                              to_cnt <= to_cnt + 1'b1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      is_write  <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      byte_cnt  <= '0;
      reply_buf <= '0;
      reply_rem <= '0;
    end else begin
      case (state)
        S_CMD: if (rx_valid) begin
          is_write <= (rx_shift == CMD_W);
          byte_cnt <= 2'd0;
          if (!is_cmd) begin
            reply_buf <= {RSP_UNK, 24'h0};
            reply_rem <= 3'd1;
          end
        end
        S_ADDR: if (rx_valid) begin
          addr     <= {addr[23:0], rx_shift};
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_DATA: if (rx_valid) begin
          wdata    <= {wdata[23:0], rx_shift};
          byte_cnt <= byte_cnt + 2'd1;
        end
        S_AHB_D: if (ahb.HREADY) begin
          if (ahb.HRESP) begin
            reply_buf <= {RSP_E, 24'h0};
            reply_rem <= 3'd1;
          end else if (is_write) begin
            reply_buf <= {RSP_K, 24'h0};
            reply_rem <= 3'd1;
          end else begin
            reply_buf <= ahb.HRDATA;
            reply_rem <= 3'd4;
          end
        end
        S_REPLY: if (tx_load) begin
          reply_buf <= {reply_buf[23:0], 8'h0};
          reply_rem <= reply_rem - 3'd1;
        end
        default: ;
      endcase
`ifdef AHB_UART_TIMEOUT_EN
      if (timeout_hit) begin
        reply_buf <= {RSP_T, 24'h0};
        reply_rem <= 3'd1;
      end
`endif
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= S_CMD;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    tx_load    = 1'b0;
    htrans     = 2'b00;
    hsel       = 1'b0;
    hwrite     = 1'b0;
    case (state)
      S_CMD:
        if (rx_valid) state_next = is_cmd ? S_ADDR : S_REPLY;
      S_ADDR:
        if (rx_ferr) state_next = S_CMD;
        else if (rx_valid && byte_cnt == 2'd3) state_next = is_write ? S_DATA : S_AHB_A;
      S_DATA:
        if (rx_ferr) state_next = S_CMD;
        else if (rx_valid && byte_cnt == 2'd3) state_next = S_AHB_A;
      S_AHB_A: begin
        htrans = 2'b10;
        hsel   = 1'b1;
        hwrite = is_write;
        if (ahb.HREADY) state_next = S_AHB_D;
      end
      S_AHB_D:
        if (ahb.HREADY) state_next = S_REPLY;
      S_REPLY:
        if (tx_ready) begin
          if (reply_rem != 3'd0) tx_load    = 1'b1;
          else                   state_next = S_CMD;
        end
      default: state_next = S_CMD;
    endcase
    if (timeout_hit) state_next = S_REPLY;
  end

  assign ahb.HADDR  = {addr[31:2], 2'b00};
  assign ahb.HBURST = 3'b000;
  assign ahb.HSIZE  = 3'b010;
  assign ahb.HTRANS = htrans;
  assign ahb.HSEL   = hsel;
  assign ahb.HWRITE = hwrite;
  assign ahb.HWDATA = wdata;
  assign BUSY       = (state != S_CMD);

endmodule

// File: tb/tb_ahb_lite_uart_master.sv
// tb/tb_ahb_lite_uart_master.sv - self-checking bench for ahb_lite_uart_master
module tb_ahb_lite_uart_master;
  localparam int BD = 8;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;
  logic UART_RX = 1'b1;
  logic UART_TX;
  logic BUSY;

  ahb_lite_uart_master_if bus();

  ahb_lite_uart_master #(.BAUD_DIV(BD)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .UART_RX(UART_RX),
    .UART_TX(UART_TX), .BUSY(BUSY), .ahb(bus)
  );

  always #5 HCLK = ~HCLK;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
  } xfer_t;

  logic [7:0] exp_tx[$];
  xfer_t      exp_bus[$];

  // Slave configuration for the next transfer
  int          s_aw = 0;
  int          s_dw = 0;
  logic [31:0] s_rdata = '0;
  logic        s_resp = 1'b0;
  bit          stall = 1'b0;
  int          n_xfer = 0;
  int          nonseq_cycles = 0;

  always @(negedge HCLK)
    if (HRESETn && bus.HSEL && bus.HTRANS == 2'b10) nonseq_cycles <= nonseq_cycles + 1;

  // AHB slave model
  initial begin : slave
    logic [31:0] a0;
    logic        w0;
    xfer_t       e;
    bus.HREADY = 1'b1;
    bus.HRDATA = '0;
    bus.HRESP  = 1'b0;
    forever begin
      @(negedge HCLK);
      if (stall) begin
        bus.HREADY = 1'b0;
      end else begin
        bus.HREADY = 1'b1;
        if (HRESETn && bus.HSEL && bus.HTRANS == 2'b10) begin
          n_xfer++;
          a0 = bus.HADDR;
          w0 = bus.HWRITE;
          if (s_aw > 0) begin
            bus.HREADY = 1'b0;
            for (int k = 0; k < s_aw; k++) begin
              @(negedge HCLK);
              chk("addr_hold_htrans", 32'(bus.HTRANS), 32'd2);
              chk("addr_hold_haddr", bus.HADDR, a0);
            end
            bus.HREADY = 1'b1;
          end
          @(negedge HCLK);
          chk("dphase_htrans", 32'(bus.HTRANS), 32'd0);
          chk("dphase_hsel", 32'(bus.HSEL), 32'd0);
          chk("xfer_expected", 32'(exp_bus.size() > 0), 32'd1);
          if (exp_bus.size() > 0) begin
            e = exp_bus.pop_front();
            chk("haddr", a0, e.addr);
            chk("hwrite", 32'(w0), 32'(e.write));
            if (e.write) chk("hwdata", bus.HWDATA, e.wdata);
          end
          if (s_dw > 0) begin
            bus.HREADY = 1'b0;
            repeat (s_dw) @(negedge HCLK);
          end
          bus.HREADY = 1'b1;
          bus.HRDATA = s_rdata;
          bus.HRESP  = s_resp;
          @(negedge HCLK);
          bus.HRDATA = '0;
          bus.HRESP  = 1'b0;
        end
      end
    end
  end

  // UART TX monitor: decodes bytes and pops the scoreboard
  initial begin : tx_mon
    logic [7:0] b;
    logic [7:0] e;
    forever begin
      @(negedge HCLK);
      if (HRESETn && UART_TX == 1'b0) begin
        repeat (BD / 2) @(negedge HCLK);
        if (UART_TX == 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (BD) @(negedge HCLK);
            b[i] = UART_TX;
          end
          repeat (BD) @(negedge HCLK);
          chk("tx_stop", 32'(UART_TX), 32'd1);
          chk("tx_expected", 32'(exp_tx.size() > 0), 32'd1);
          if (exp_tx.size() > 0) begin
            e = exp_tx.pop_front();
            chk("tx_byte", 32'(b), 32'(e));
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge HCLK);
    UART_RX = 1'b0;
    repeat (BD) @(negedge HCLK);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (BD) @(negedge HCLK);
    end
    UART_RX = stop_ok;
    repeat (BD) @(negedge HCLK);
    UART_RX = 1'b1;
    if (!stop_ok) repeat (BD) @(negedge HCLK);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (BUSY === 1'b1 && n < 5000) begin
      @(negedge HCLK);
      n++;
    end
    chk({nm, "_busy_fall"}, 32'(BUSY), 32'd0);
    repeat (2 * BD) @(negedge HCLK);
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        resp;
    int          aw;
    int          dw;
    logic [31:0] exp_haddr;
    int          exp_n;
    logic [31:0] exp_reply;
  } vec_t;

  task automatic run_vec(input string nm, input vec_t v);
    int    xb;
    int    nb;
    bit    is_bus;
    xfer_t x;
    is_bus  = (v.cmd == 8'h57) || (v.cmd == 8'h52);
    s_aw    = v.aw;
    s_dw    = v.dw;
    s_rdata = v.rdata;
    s_resp  = v.resp;
    for (int i = 0; i < v.exp_n; i++) exp_tx.push_back(v.exp_reply[31 - 8*i -: 8]);
    if (is_bus) begin
      x.addr  = v.exp_haddr;
      x.write = (v.cmd == 8'h57);
      x.wdata = v.wdata;
      exp_bus.push_back(x);
    end
    xb = n_xfer;
    nb = nonseq_cycles;
    send_byte(v.cmd, 1'b1);
    chk({nm, "_busy_rise"}, 32'(BUSY), 32'd1);
    if (is_bus) for (int i = 0; i < 4; i++) send_byte(v.addr[31 - 8*i -: 8], 1'b1);
    if (v.cmd == 8'h57) for (int i = 0; i < 4; i++) send_byte(v.wdata[31 - 8*i -: 8], 1'b1);
    wait_idle(nm);
    chk({nm, "_xfers"}, 32'(n_xfer - xb), is_bus ? 32'd1 : 32'd0);
    chk({nm, "_nonseq_cycles"}, 32'(nonseq_cycles - nb), is_bus ? 32'(v.aw + 1) : 32'd0);
    chk({nm, "_tx_drained"}, 32'(exp_tx.size()), 32'd0);
    chk({nm, "_bus_drained"}, 32'(exp_bus.size()), 32'd0);
    exp_tx.delete();
    exp_bus.delete();
  endtask

  vec_t vecs[9];

  initial begin : main
    int xb;
    vecs[0] = '{8'h57, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,         1'b0, 0, 0, 32'h0000_0010, 1, 32'h4B00_0000};
    vecs[1] = '{8'h52, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0, 0, 0, 32'h0000_0010, 4, 32'hDEAD_BEEF};
    vecs[2] = '{8'h57, 32'h0000_0020, 32'h1234_5678, 32'h0,         1'b0, 5, 0, 32'h0000_0020, 1, 32'h4B00_0000};
    vecs[3] = '{8'h41, 32'h0,         32'h0,         32'h0,         1'b0, 0, 0, 32'h0,         1, 32'h3F00_0000};
    vecs[4] = '{8'h52, 32'h0000_0004, 32'h0,         32'hCAFE_F00D, 1'b0, 0, 0, 32'h0000_0004, 4, 32'hCAFE_F00D};
    vecs[5] = '{8'h52, 32'h0000_0013, 32'h0,         32'hA5C3_0F96, 1'b0, 0, 3, 32'h0000_0010, 4, 32'hA5C3_0F96};
    vecs[6] = '{8'h57, 32'h0000_0040, 32'h0,         32'h0,         1'b1, 0, 0, 32'h0000_0040, 1, 32'h4500_0000};
    vecs[7] = '{8'h52, 32'h8000_0044, 32'h0,         32'h1111_1111, 1'b1, 2, 2, 32'h8000_0044, 1, 32'h4500_0000};
    vecs[8] = '{8'h57, 32'h0000_007F, 32'h00FF_00FF, 32'h0,         1'b0, 1, 1, 32'h0000_007C, 1, 32'h4B00_0000};

    repeat (3) @(negedge HCLK);
    chk("rst_uart_tx", 32'(UART_TX), 32'd1);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_htrans", 32'(bus.HTRANS), 32'd0);
    chk("rst_hsel", 32'(bus.HSEL), 32'd0);
    chk("rst_haddr", bus.HADDR, 32'd0);
    chk("rst_hwdata", bus.HWDATA, 32'd0);
    chk("rst_hwrite", 32'(bus.HWRITE), 32'd0);
    chk("rst_hsize", 32'(bus.HSIZE), 32'd2);
    chk("rst_hburst", 32'(bus.HBURST), 32'd0);
    HRESETn = 1'b1;
    repeat (4) @(negedge HCLK);

    for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Framing error in the middle of the address field aborts the command
    xb = n_xfer;
    send_byte(8'h57, 1'b1);
    chk("ferr_busy_rise", 32'(BUSY), 32'd1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h10, 1'b0);
    repeat (BD) @(negedge HCLK);
    chk("ferr_busy_drop", 32'(BUSY), 32'd0);
    repeat (20 * BD) @(negedge HCLK);
    chk("ferr_no_xfer", 32'(n_xfer - xb), 32'd0);
    chk("ferr_idle_htrans", 32'(bus.HTRANS), 32'd0);
    run_vec("after_ferr", '{8'h57, 32'h0000_0030, 32'h1122_3344, 32'h0, 1'b0, 0, 0,
                            32'h0000_0030, 1, 32'h4B00_0000});

`ifdef AHB_UART_TIMEOUT_EN
    begin : timeout_seq
      int nb;
      stall = 1'b1;
      nb = nonseq_cycles;
      exp_tx.push_back(8'h54);
      send_byte(8'h52, 1'b1);
      for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
      send_byte(8'h08, 1'b1);
      wait_idle("timeout");
      chk("timeout_nonseq_cycles", 32'(nonseq_cycles - nb), 32'd1024);
      chk("timeout_htrans", 32'(bus.HTRANS), 32'd0);
      chk("timeout_tx_drained", 32'(exp_tx.size()), 32'd0);
      exp_tx.delete();
      stall = 1'b0;
      repeat (4) @(negedge HCLK);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
